// File: rtl/program_loader.sv
// program_loader: receives a program as a byte stream on a valid/ready link.
// Frame layout: LEN_H, LEN_L, then N instruction words sent high byte first.
// Each word is written to instruction memory, starting at address 0.
// cpu_hold keeps the control unit parked until a complete load succeeds.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing CHK byte must equal the XOR of every data byte.
module program_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mi_we,
  output logic [ADDR_W-1:0] mi_addr,
  output logic [15:0]       mi_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // One extra counter bit, so a full-depth load reaches DEPTH without wrapping.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_H  = 3'd1,
    S_LEN_L  = 3'd2,
    S_DATA_H = 3'd3,
    S_DATA_L = 3'd4,
    S_CHK    = 3'd5,
    S_FIN    = 3'd6,
    S_ERR    = 3'd7
  } state_e;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // After the last data word the frame still carries the checksum byte.
  localparam state_e S_AFTER_DATA = S_CHK;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [7:0] csum_q, csum_d;
`else
  localparam state_e S_AFTER_DATA = S_FIN;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         hi_q, hi_d;
  logic               rx_ready_q, rx_ready_d;
  logic               mi_we_q, mi_we_d;
  logic [ADDR_W-1:0]  mi_addr_q, mi_addr_d;
  logic [15:0]        mi_wdata_q, mi_wdata_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_s;
  logic [15:0]        len_full_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               len_too_big_s;
  logic               last_word_s;

  assign xfer_s        = rx_valid & rx_ready_q;
  assign len_full_s    = {len_q[15:8], rx_data};
  assign cnt_inc_s     = cnt_q + CNT_ONE;
  assign len_too_big_s = (32'(len_full_s) > DEPTH);
  assign last_word_s   = (32'(cnt_inc_s) == 32'(len_q));

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hi_d       = hi_q;
    mi_we_d    = 1'b0;
    mi_addr_d  = mi_addr_q;
    mi_wdata_d = mi_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        if (load_start) begin
          state_d    = S_LEN_H;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          cnt_d      = CNT_ZERO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_H: begin
        if (xfer_s) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = S_LEN_L;
        end else begin
          state_d = S_LEN_H;
        end
      end
      S_LEN_L: begin
        if (xfer_s) begin
          len_d = len_full_s;
          if (len_too_big_s) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end else if (len_full_s == 16'h0000) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA_H;
          end
        end else begin
          state_d = S_LEN_L;
        end
      end
      S_DATA_H: begin
        if (xfer_s) begin
          hi_d    = rx_data;
          state_d = S_DATA_L;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_update(csum_q, rx_data);
`endif
        end else begin
          state_d = S_DATA_H;
        end
      end
      S_DATA_L: begin
        if (xfer_s) begin
          mi_we_d    = 1'b1;
          mi_addr_d  = cnt_q[ADDR_W-1:0];
          mi_wdata_d = {hi_q, rx_data};
          cnt_d      = cnt_inc_s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_update(csum_q, rx_data);
`endif
          if (last_word_s) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA_H;
          end
        end else begin
          state_d = S_DATA_L;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer_s) begin
          if (rx_data == csum_q) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end else begin
          state_d = S_CHK;
        end
      end
`endif
      S_FIN: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d    = S_ERR;
        err_d      = 1'b1;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // rx_ready is registered, so it is derived from the state being entered.
  always_comb begin
    rx_ready_d = 1'b0;
    case (state_d)
      S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L: rx_ready_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK:                                rx_ready_d = 1'b1;
`endif
      default:                              rx_ready_d = 1'b0;
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      len_q      <= 16'h0000;
      hi_q       <= 8'h00;
      rx_ready_q <= 1'b0;
      mi_we_q    <= 1'b0;
      mi_addr_q  <= {ADDR_W{1'b0}};
      mi_wdata_q <= 16'h0000;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      rx_ready_q <= rx_ready_d;
      mi_we_q    <= mi_we_d;
      mi_addr_q  <= mi_addr_d;
      mi_wdata_q <= mi_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign mi_we    = mi_we_q;
  assign mi_addr  = mi_addr_q;
  assign mi_wdata = mi_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Frames are built from random or fixed word
// lists; the expected memory writes and done/err events are queued when each
// frame is issued, and a negedge monitor pops and compares them.
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  typedef logic [15:0] wq_t[$];
  typedef logic [7:0]  bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic              clock      = 1'b0;
  logic              reset      = 1'b0;
  logic              load_start = 1'b0;
  logic [7:0]        rx_data    = 8'h00;
  logic              rx_valid   = 1'b0;
  logic              rx_ready;
  logic              mi_we;
  logic [ADDR_W-1:0] mi_addr;
  logic [15:0]       mi_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_wr[$];
  int  exp_ev[$];   // 0 = done pulse, 1 = err raised
  logic err_prev = 1'b0;

  always #5 clock = ~clock;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mi_we(mi_we), .mi_addr(mi_addr), .mi_wdata(mi_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write, done pulse and err rise must match the scoreboard.
  always @(negedge clock) begin
    wr_t e;
    int  ev;
    if (reset) begin
      if (mi_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mi_addr, mi_wdata);
        end else begin
          e = exp_wr.pop_front();
          check32("wr_addr", 32'(mi_addr), 32'(e.addr));
          check32("wr_data", 32'(mi_wdata), 32'(e.data));
        end
      end
      if (done) begin
        if (exp_ev.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done pulse with no event expected");
        end else begin
          ev = exp_ev.pop_front();
          check32("event_kind_done", 32'd0, 32'(ev));
        end
      end
      if (err && !err_prev) begin
        if (exp_ev.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err: err raised with no event expected");
        end else begin
          ev = exp_ev.pop_front();
          check32("event_kind_err", 32'd1, 32'(ev));
        end
      end
    end
    err_prev = err;
  end

  task automatic pulse_start();
    @(negedge clock);
    rx_valid   = 1'b0;
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Presents bytes in order; returns right after the edge that takes the last one.
  task automatic send_bytes(input bq_t b, input bit gappy);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < b.size()) begin
      @(negedge clock);
      rx_data  = b[i];
      rx_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      acc      = rx_valid && rx_ready;
      @(posedge clock);
      if (acc) i++;
      guard++;
      if (guard > 4000) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d of %0d not accepted", i, b.size());
        break;
      end
    end
  endtask

  // Builds a frame, queues its expected effects, sends it, and checks the ending.
  task automatic run_frame(input int n, input wq_t words, input bit gappy,
                           input bit bad_chk, input bit skip_start);
    bq_t         b;
    logic [15:0] nn;
    logic [7:0]  x;
    bit          chk_fail;
    wr_t         e;
    nn       = 16'(n);
    x        = 8'h00;
    chk_fail = HAS_CHK && bad_chk;
    b.push_back(nn[15:8]);
    b.push_back(nn[7:0]);
    if (n > DEPTH) begin
      exp_ev.push_back(1);
    end else begin
      for (int i = 0; i < n; i++) begin
        b.push_back(words[i][15:8]);
        b.push_back(words[i][7:0]);
        x = x ^ words[i][15:8] ^ words[i][7:0];
        e.addr = ADDR_W'(i);
        e.data = words[i];
        exp_wr.push_back(e);
      end
      if (HAS_CHK) b.push_back(chk_fail ? (x ^ 8'h01) : x);
      exp_ev.push_back(chk_fail ? 1 : 0);
    end
    if (!skip_start) pulse_start();
    send_bytes(b, gappy);
    @(negedge clock);
    rx_valid = 1'b0;
    if (n > DEPTH) begin
      check1("len_err", err, 1'b1);
      check1("len_err_ready", rx_ready, 1'b0);
      check1("len_err_hold", cpu_hold, 1'b1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
      end
      @(negedge clock);
      rx_valid = 1'b0;
      check1("err_ready_stays_low", rx_ready, 1'b0);
      check1("err_sticky", err, 1'b1);
    end else if (chk_fail) begin
      check1("chk_err", err, 1'b1);
      check1("chk_err_hold", cpu_hold, 1'b1);
      check1("chk_err_ready", rx_ready, 1'b0);
      check1("chk_err_no_done", done, 1'b0);
    end else begin
      check1("first_we", mi_we, (n > 0) && !HAS_CHK);
      check1("done_not_early", done, 1'b0);
      @(negedge clock);
      check1("done_pulse", done, 1'b1);
      check1("hold_released", cpu_hold, 1'b0);
      check1("ready_idle", rx_ready, 1'b0);
      @(negedge clock);
      check1("done_one_cycle", done, 1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w;
    wq_t empty;
    bq_t b;
    wr_t e;
    int  n;

    // Reset values
    @(negedge clock);
    check1("rst_ready", rx_ready, 1'b0);
    check1("rst_we", mi_we, 1'b0);
    check32("rst_addr", 32'(mi_addr), 32'd0);
    check32("rst_wdata", 32'(mi_wdata), 32'd0);
    check1("rst_hold", cpu_hold, 1'b1);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Reset asserted while the loader waits for a low byte
    w = {};
    for (int i = 0; i < 4; i++) w.push_back(16'($urandom) | 16'h0101);
    b = {8'h00, 8'h04, w[0][15:8], w[0][7:0], w[1][15:8], w[1][7:0],
         w[2][15:8], w[2][7:0], w[3][15:8]};
    for (int i = 0; i < 3; i++) begin
      e.addr = ADDR_W'(i);
      e.data = w[i];
      exp_wr.push_back(e);
    end
    pulse_start();
    send_bytes(b, 1'b0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check1("midrst_ready", rx_ready, 1'b0);
    check1("midrst_we", mi_we, 1'b0);
    check32("midrst_addr", 32'(mi_addr), 32'd0);
    check32("midrst_wdata", 32'(mi_wdata), 32'd0);
    check1("midrst_hold", cpu_hold, 1'b1);
    check1("midrst_done", done, 1'b0);
    check1("midrst_err", err, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check1("idle_ready_low", rx_ready, 1'b0);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clock);
    rx_valid = 1'b0;

    // Fixed two-word frame, streamed then with gaps
    w = {16'hA53C, 16'h1234};
    run_frame(2, w, 1'b0, 1'b0, 1'b0);
    run_frame(2, w, 1'b1, 1'b0, 1'b0);

    // Length above depth, then recovery via load_start
    run_frame(DEPTH + 1, empty, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check1("restart_err_clear", err, 1'b0);
    check1("restart_ready", rx_ready, 1'b1);
    check1("restart_hold", cpu_hold, 1'b1);
    run_frame(0, empty, 1'b0, 1'b0, 1'b1);

    // Empty program
    run_frame(0, empty, 1'b0, 1'b0, 1'b0);

    // Single word with correct and corrupted checksum
    w = {16'hF00F};
    run_frame(1, w, 1'b0, 1'b0, 1'b0);
    run_frame(1, w, 1'b0, 1'b1, 1'b0);

    // Full-depth program
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom));
    run_frame(DEPTH, w, 1'b0, 1'b0, 1'b0);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_frame(n, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clock);
    check32("writes_drained", 32'(exp_wr.size()), 32'd0);
    check32("events_drained", 32'(exp_ev.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
